// File: rtl/icache_line_adapter.sv
// icache_line_adapter: assembles one cache line from four memory beats.
// A fill request in IDLE latches the line-aligned address. FILL holds
// burst_read high and writes each accepted beat into its line slot. DONE
// pulses mem_resp for one cycle with the complete line.

// One beat slot of the line buffer. It loads only when its beat index is accepted.
module icache_line_beat #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Beat storage. It keeps its value until the same slot is written by a later fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (we) q <= d;
  end

endmodule

module icache_line_adapter #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pmem_read,
  input  logic [31:0]        pmem_address,
  output logic [s_line-1:0]  pmem_rdata,
  output logic               mem_resp,
  output logic               burst_read,
  output logic [31:0]        burst_address,
  input  logic [s_burst-1:0] burst_rdata,
  input  logic               burst_resp
);

  localparam int          NUM_BEATS = 4;
  // Clears the byte offset within a line. This is [4:0] for 32-byte lines.
  localparam logic [31:0] LINE_MASK = ~(32'(s_line / 8) - 32'd1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                              state, state_nx;
  logic [1:0]                          k;
  logic                                beat_we;
  logic                                start;
  logic [NUM_BEATS-1:0][s_burst-1:0]   beats;

  assign start = (state == IDLE) && pmem_read;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and outputs. Beats are accepted only in FILL, so stray
  // burst_resp in IDLE or DONE has no effect.
  always_comb begin
    state_nx   = state;
    burst_read = 1'b0;
    mem_resp   = 1'b0;
    beat_we    = 1'b0;
    case (state)
      IDLE: if (pmem_read) state_nx = FILL;
      FILL: begin
        burst_read = 1'b1;
        if (burst_resp) begin
          beat_we = 1'b1;
          if (k == 2'd3) state_nx = DONE;
        end
      end
      DONE: begin
        mem_resp = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Beat counter. It clears on fill start, and beat 3 wraps it back to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         k <= '0;
    else if (start)   k <= '0;
    else if (beat_we) k <= k + 2'd1;
  end

  // Line address. It is latched only on the IDLE->FILL transition, so later
  // changes to pmem_address are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       burst_address <= '0;
    else if (start) burst_address <= pmem_address & LINE_MASK;
  end

  for (genvar b = 0; b < NUM_BEATS; b++) begin : g_beat
    localparam logic [1:0] IDX = b;
    icache_line_beat #(.W(s_burst)) u_beat (
      .clk (clk),
      .rst (rst),
      .we  (beat_we && (k == IDX)),
      .d   (burst_rdata),
      .q   (beats[b])
    );
  end

  assign pmem_rdata = beats;

endmodule

// File: doc/icache_line_adapter.md
ICACHE_LINE_ADAPTER -- requirements
Module: icache_line_adapter

Interface
REQ-001 Parameter s_line, default 256, SHALL set the cache line width in bits.
REQ-002 Parameter s_burst, default 64, SHALL set the memory beat width in bits; s_line SHALL equal 4*s_burst.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 pmem_read  input  1  SHALL be the line-fill request from the icache datapath/control.
REQ-006 pmem_address  input  32  SHALL be the byte address of the requested line.
REQ-007 pmem_rdata  output  s_line  SHALL be the assembled line returned to the icache.
REQ-008 mem_resp  output  1  SHALL be the one-cycle fill-complete strobe to the icache.
REQ-009 burst_read  output  1  SHALL be the read request to physical memory.
REQ-010 burst_address  output  32  SHALL be the line-aligned address presented to physical memory.
REQ-011 burst_rdata  input  s_burst  SHALL be one beat of returned memory data.
REQ-012 burst_resp  input  1  SHALL qualify burst_rdata as a valid beat in the same cycle.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, FILL, DONE.
REQ-014 IDLE: if pmem_read=1 at a rising edge, the block SHALL latch {pmem_address[31:5], 5'b0} into burst_address, clear the beat counter, and enter FILL.
REQ-015 FILL: burst_read SHALL be 1 every cycle in FILL and 0 in IDLE and DONE.
REQ-016 FILL: each edge with burst_resp=1 SHALL write burst_rdata into pmem_rdata[64k+63:64k], where k is the 2-bit beat counter, then increment k.
REQ-017 Beats MAY be non-contiguous; cycles with burst_resp=0 SHALL leave pmem_rdata and k unchanged.
REQ-018 On the edge accepting beat k=3, the FSM SHALL enter DONE and k SHALL wrap to 0.
REQ-019 DONE: mem_resp SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-020 pmem_rdata SHALL be fully assembled and stable during the mem_resp cycle and SHALL hold its value until the next FILL writes beat 0.
REQ-021 burst_address SHALL remain constant from FILL entry until the next IDLE->FILL transition.
REQ-022 Minimum latency: pmem_read sampled at edge 0, four back-to-back beats at edges 1-4, mem_resp=1 in the cycle after edge 4.
REQ-023 pmem_read deasserted during FILL SHALL NOT abort the burst; the fill completes and mem_resp still pulses.
REQ-024 pmem_read=1 in DONE SHALL be ignored; if still 1 in the following IDLE cycle, a new fill SHALL start.
REQ-025 burst_resp=1 in IDLE or DONE SHALL be ignored with no state or data change.
REQ-026 Changes of pmem_address during FILL or DONE SHALL NOT affect burst_address.

Reset
REQ-027 rst=0 SHALL immediately, independent of clk, force FSM=IDLE, k=0, burst_read=0, mem_resp=0, burst_address=0, pmem_rdata=0.
REQ-028 Reset asserted mid-FILL SHALL abandon the burst; beats arriving after reset release SHALL be ignored per REQ-025.
REQ-029 After rst returns to 1, the first edge with pmem_read=1 SHALL start a fill per REQ-014.

Verification
REQ-030 Back-to-back fill: pmem_address=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 at consecutive edges -> burst_address=0x0000_1220, mem_resp one cycle after beat 4, pmem_rdata={0x44..44,0x33..33,0x22..22,0x11..11}.
REQ-031 Gapped beats: burst_resp pattern 1,0,0,1,1,0,1 -> exactly four beats captured in order, mem_resp one cycle after seventh cycle, burst_read high for all seven cycles.
REQ-032 Request dropped mid-fill: pmem_read deasserted after beat 1 -> remaining beats captured, mem_resp pulses once, FSM returns to IDLE and does not restart.
REQ-033 Held request: pmem_read kept 1 through DONE -> second fill starts in the IDLE cycle after mem_resp with a freshly latched address.
REQ-034 Async reset mid-fill: rst=0 between edges after beat 2 -> all outputs zero before the next edge; stray beats after release ignored; next fill completes normally.
REQ-035 Idle noise: burst_resp=1 with pmem_read=0 for 10 cycles -> pmem_rdata, burst_read and mem_resp unchanged at 0.
